regfile_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port 16x8 register file among several requesters (instruction fetch/decode operand reads, ALU writeback, debug/monitor port). Each cycle it grants at most one requester, drives the register file's address/data/wr/rd strobes, and returns read data one cycle later, tagged with the requester index. It supports short locked sequences for read-modify-write. It forwards write data to a read of the same address issued in the following cycle, covering the register file's one-cycle write commit.

---
 rtl/regfile_arbiter_pkg.sv | 18 +
 rtl/regfile_arbiter_rr_select.sv | 42 ++++
 rtl/regfile_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared constants and types for the register-file arbiter slice.
package regfile_arbiter_pkg;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int RID_W = 2;

    localparam int REQ_DECODE = 0;
    localparam int REQ_WB     = 1;
    localparam int REQ_DBG    = 2;

    typedef logic [RID_W-1:0] rid_t;

    function automatic rid_t wrap_inc(input rid_t i, input int n);
        return (int'(i) == n - 1) ? '0 : rid_t'(i + 1'b1);
    endfunction

endpackage

// File: rtl/regfile_arbiter_rr_select.sv
// Rotate-priority picker: first requester at or after rr_ptr, wrapping to 0.
module regfile_arbiter_rr_select
    import regfile_arbiter_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  rid_t            rr_ptr,
    output logic [NREQ-1:0] gnt,
    output rid_t            idx,
    output logic            valid
);

    localparam logic [RID_W:0] NREQ_W = (RID_W+1)'(NREQ);

    rid_t            cand [NREQ];
    rid_t            idx_acc [NREQ+1];
    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] hit;

    assign idx_acc[0] = '0;
    assign valid      = |req;
    assign idx        = idx_acc[NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_pos
            logic [RID_W:0] sum;
            // Position gi in search order maps to requester (rr_ptr + gi) mod NREQ.
            assign sum      = {1'b0, rr_ptr} + (RID_W+1)'(gi);
            assign cand[gi] = (sum >= NREQ_W) ? rid_t'(sum - NREQ_W) : rid_t'(sum);
            assign rot[gi]  = req[cand[gi]];
            if (gi == 0) begin : g_first
                assign hit[gi] = rot[0];
            end else begin : g_rest
                assign hit[gi] = rot[gi] & ~(|rot[gi-1:0]);
            end
            assign idx_acc[gi+1] = idx_acc[gi] | (hit[gi] ? cand[gi] : '0);
            assign gnt[gi]       = valid && (idx == rid_t'(gi));
        end
    endgenerate

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter for a single-port register file, with short locks,
// one-cycle write forwarding and a tagged, registered read return.
module regfile_arbiter #(
    parameter int NREQ     = 3,
    parameter int DW       = regfile_arbiter_pkg::DW,
    parameter int AW       = regfile_arbiter_pkg::AW,
    parameter int LOCK_MAX = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NREQ-1:0]                     req,
    input  logic [NREQ-1:0]                     we,
    input  logic [NREQ-1:0]                     lock,
    input  logic [NREQ*AW-1:0]                  addr,
    input  logic [NREQ*DW-1:0]                  wdata,
    output logic [NREQ-1:0]                     gnt,
    output logic                                rvalid,
    output logic [regfile_arbiter_pkg::RID_W-1:0] rid,
    output logic [DW-1:0]                       rdata,
    output logic [AW-1:0]                       rf_address,
    output logic [DW-1:0]                       rf_in_data,
    output logic                                rf_wr,
    output logic                                rf_rd,
    input  logic [DW-1:0]                       rf_out_data
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    typedef logic [regfile_arbiter_pkg::RID_W-1:0] idx_t;

    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    idx_t             rr_ptr_reg;
    idx_t             lock_owner_reg;
    logic             lock_active_reg;
    logic [CNT_W-1:0] lock_cnt_reg;
    logic             fwd_valid_reg;
    logic [AW-1:0]    fwd_addr_reg;
    logic [DW-1:0]    fwd_data_reg;
    logic             rvalid_reg;
    idx_t             rid_reg;
    logic [DW-1:0]    rdata_reg;

    logic [NREQ-1:0] rr_gnt;
    idx_t            rr_idx;
    logic            rr_valid;
    logic            lock_hold;
    logic            sel_valid;
    idx_t            sel_idx;
    logic [NREQ-1:0] lock_gnt;
    logic [DW-1:0]   read_data;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*AW +: AW];
            assign wdata_arr[gi] = wdata[gi*DW +: DW];
        end
    endgenerate

    regfile_arbiter_rr_select #(
        .NREQ (NREQ)
    ) u_rr_select (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .gnt    (rr_gnt),
        .idx    (rr_idx),
        .valid  (rr_valid)
    );

    // A held lock bypasses round-robin until the owner has had LOCK_MAX grants.
    assign lock_hold = lock_active_reg && req[lock_owner_reg] && (lock_cnt_reg < LOCK_MAX_C);

    always_comb begin
        lock_gnt                 = '0;
        lock_gnt[lock_owner_reg] = 1'b1;
        sel_valid  = !reset && (lock_hold || rr_valid);
        sel_idx    = lock_hold ? lock_owner_reg : rr_idx;
        gnt        = '0;
        rf_address = '0;
        rf_in_data = '0;
        rf_wr      = 1'b0;
        rf_rd      = 1'b0;
        if (sel_valid) begin
            gnt        = lock_hold ? lock_gnt : rr_gnt;
            rf_address = addr_arr[sel_idx];
            rf_in_data = wdata_arr[sel_idx];
            rf_wr      = we[sel_idx];
            rf_rd      = !we[sel_idx];
        end
        // The file has not committed last cycle's write yet, so serve it from here.
        read_data = (fwd_valid_reg && (fwd_addr_reg == addr_arr[sel_idx])) ? fwd_data_reg : rf_out_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_reg      <= '0;
            lock_owner_reg  <= '0;
            lock_active_reg <= 1'b0;
            lock_cnt_reg    <= '0;
            fwd_valid_reg   <= 1'b0;
            fwd_addr_reg    <= '0;
            fwd_data_reg    <= '0;
            rvalid_reg      <= 1'b0;
            rid_reg         <= '0;
            rdata_reg       <= '0;
        end else begin
            if (sel_valid) begin
                rr_ptr_reg <= regfile_arbiter_pkg::wrap_inc(sel_idx, NREQ);
            end
            if (sel_valid && lock[sel_idx]) begin
                lock_active_reg <= 1'b1;
                lock_owner_reg  <= sel_idx;
                lock_cnt_reg    <= lock_hold ? lock_cnt_reg + CNT_W'(1) : CNT_W'(1);
            end else begin
                lock_active_reg <= 1'b0;
                lock_cnt_reg    <= '0;
            end
            fwd_valid_reg <= sel_valid && we[sel_idx];
            if (sel_valid && we[sel_idx]) begin
                fwd_addr_reg <= addr_arr[sel_idx];
                fwd_data_reg <= wdata_arr[sel_idx];
            end
            rvalid_reg <= sel_valid && !we[sel_idx];
            if (sel_valid && !we[sel_idx]) begin
                rid_reg   <= sel_idx;
                rdata_reg <= read_data;
            end
        end
    end

    assign rvalid = rvalid_reg;
    assign rid    = rid_reg;
    assign rdata  = rdata_reg;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed, table-driven bench for regfile_arbiter with a delayed-commit register file model.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, we, lock;
    logic [11:0] addr;
    logic [23:0] wdata;
    logic [2:0]  gnt;
    logic        rvalid;
    logic [1:0]  rid;
    logic [7:0]  rdata;
    logic [3:0]  rf_address;
    logic [7:0]  rf_in_data;
    logic        rf_wr, rf_rd;
    logic [7:0]  rf_out_data;

    always #5 clk = ~clk;

    regfile_arbiter #(
        .NREQ(3), .DW(8), .AW(4), .LOCK_MAX(4)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rid(rid),
        .rdata(rdata), .rf_address(rf_address), .rf_in_data(rf_in_data),
        .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_out_data(rf_out_data)
    );

    // Register file: writes land one edge after the access edge; contents preset to 0x10+a.
    logic [7:0] mem [16];
    logic       pend_wr;
    logic [3:0] pend_a;
    logic [7:0] pend_d;

    assign rf_out_data = mem[rf_address];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
            pend_wr <= 1'b0;
            pend_a  <= '0;
            pend_d  <= '0;
        end else begin
            if (pend_wr) mem[pend_a] <= pend_d;
            pend_wr <= rf_wr;
            pend_a  <= rf_address;
            pend_d  <= rf_in_data;
        end
    end

    typedef struct {
        logic [2:0]  req, we, lock;
        logic [11:0] addr;
        logic [23:0] wdata;
        logic [2:0]  e_gnt;
        logic [3:0]  e_rfa;
        logic [7:0]  e_rfd;
        logic        e_wr, e_rd, e_rvalid;
        logic [1:0]  e_rid;
        logic [7:0]  e_rdata;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                                input logic [11:0] a, input logic [23:0] d,
                                input logic [2:0] eg, input logic [3:0] ea, input logic [7:0] ed,
                                input logic ew, input logic er, input logic ev,
                                input logic [1:0] ei, input logic [7:0] edat);
        vec_t v;
        v.req = r; v.we = w; v.lock = l; v.addr = a; v.wdata = d;
        v.e_gnt = eg; v.e_rfa = ea; v.e_rfd = ed; v.e_wr = ew; v.e_rd = er;
        v.e_rvalid = ev; v.e_rid = ei; v.e_rdata = edat;
        return v;
    endfunction

    task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, n, act, exp);
        end
    endtask

    task automatic run_vec(input int n);
        req = vecs[n].req; we = vecs[n].we; lock = vecs[n].lock;
        addr = vecs[n].addr; wdata = vecs[n].wdata;
        #4;
        chk("gnt", n, 32'(gnt), 32'(vecs[n].e_gnt));
        chk("rf_address", n, 32'(rf_address), 32'(vecs[n].e_rfa));
        chk("rf_in_data", n, 32'(rf_in_data), 32'(vecs[n].e_rfd));
        chk("rf_wr", n, 32'(rf_wr), 32'(vecs[n].e_wr));
        chk("rf_rd", n, 32'(rf_rd), 32'(vecs[n].e_rd));
        @(posedge clk);
        #1;
        chk("rvalid", n, 32'(rvalid), 32'(vecs[n].e_rvalid));
        chk("rdata", n, 32'(rdata), 32'(vecs[n].e_rdata));
        if (vecs[n].e_rvalid) chk("rid", n, 32'(rid), 32'(vecs[n].e_rid));
        $display("step %0d req=%b we=%b lock=%b gnt=%b rvalid=%0b rid=%0d rdata=%02h",
                 n, vecs[n].req, vecs[n].we, vecs[n].lock, gnt, rvalid, rid, rdata);
    endtask

    initial begin
        // All-read rotation
        vecs[0]  = mk(3'b111, 3'b000, 3'b000, 12'h321, 24'h0, 3'b001, 4'h1, 8'h00, 0, 1, 1, 2'd0, 8'h11);
        vecs[1]  = mk(3'b111, 3'b000, 3'b000, 12'h321, 24'h0, 3'b010, 4'h2, 8'h00, 0, 1, 1, 2'd1, 8'h12);
        vecs[2]  = mk(3'b111, 3'b000, 3'b000, 12'h321, 24'h0, 3'b100, 4'h3, 8'h00, 0, 1, 1, 2'd2, 8'h13);
        vecs[3]  = mk(3'b111, 3'b000, 3'b000, 12'h321, 24'h0, 3'b001, 4'h1, 8'h00, 0, 1, 1, 2'd0, 8'h11);
        // Write then immediate read of same address: forwarded; later read from file
        vecs[4]  = mk(3'b010, 3'b010, 3'b000, 12'h070, 24'h00A500, 3'b010, 4'h7, 8'hA5, 1, 0, 0, 2'd0, 8'h11);
        vecs[5]  = mk(3'b001, 3'b000, 3'b000, 12'h007, 24'h0, 3'b001, 4'h7, 8'h00, 0, 1, 1, 2'd0, 8'hA5);
        vecs[6]  = mk(3'b000, 3'b000, 3'b000, 12'h000, 24'h0, 3'b000, 4'h0, 8'h00, 0, 0, 0, 2'd0, 8'hA5);
        vecs[7]  = mk(3'b001, 3'b000, 3'b000, 12'h007, 24'h0, 3'b001, 4'h7, 8'h00, 0, 1, 1, 2'd0, 8'hA5);
        // Requester 2 locks: four grants, one forced round-robin slot, then back
        vecs[8]  = mk(3'b101, 3'b000, 3'b100, 12'h301, 24'h0, 3'b100, 4'h3, 8'h00, 0, 1, 1, 2'd2, 8'h13);
        vecs[9]  = mk(3'b101, 3'b000, 3'b100, 12'h301, 24'h0, 3'b100, 4'h3, 8'h00, 0, 1, 1, 2'd2, 8'h13);
        vecs[10] = mk(3'b101, 3'b000, 3'b100, 12'h301, 24'h0, 3'b100, 4'h3, 8'h00, 0, 1, 1, 2'd2, 8'h13);
        vecs[11] = mk(3'b101, 3'b000, 3'b100, 12'h301, 24'h0, 3'b100, 4'h3, 8'h00, 0, 1, 1, 2'd2, 8'h13);
        vecs[12] = mk(3'b101, 3'b000, 3'b100, 12'h301, 24'h0, 3'b001, 4'h1, 8'h00, 0, 1, 1, 2'd0, 8'h11);
        vecs[13] = mk(3'b101, 3'b000, 3'b100, 12'h301, 24'h0, 3'b100, 4'h3, 8'h00, 0, 1, 1, 2'd2, 8'h13);
        vecs[14] = mk(3'b101, 3'b000, 3'b000, 12'h301, 24'h0, 3'b100, 4'h3, 8'h00, 0, 1, 1, 2'd2, 8'h13);
        vecs[15] = mk(3'b101, 3'b000, 3'b000, 12'h301, 24'h0, 3'b001, 4'h1, 8'h00, 0, 1, 1, 2'd0, 8'h11);
        // Bring rr_ptr to 0, idle, single read from requester 1, then rdata held
        vecs[16] = mk(3'b100, 3'b000, 3'b000, 12'h300, 24'h0, 3'b100, 4'h3, 8'h00, 0, 1, 1, 2'd2, 8'h13);
        vecs[17] = mk(3'b000, 3'b000, 3'b000, 12'h000, 24'h0, 3'b000, 4'h0, 8'h00, 0, 0, 0, 2'd0, 8'h13);
        vecs[18] = mk(3'b010, 3'b000, 3'b000, 12'h020, 24'h0, 3'b010, 4'h2, 8'h00, 0, 1, 1, 2'd1, 8'h12);
        vecs[19] = mk(3'b000, 3'b000, 3'b000, 12'h000, 24'h0, 3'b000, 4'h0, 8'h00, 0, 0, 0, 2'd0, 8'h12);
        // Write, gap, read through the file path
        vecs[20] = mk(3'b001, 3'b001, 3'b000, 12'h004, 24'h00003C, 3'b001, 4'h4, 8'h3C, 1, 0, 0, 2'd0, 8'h12);
        vecs[21] = mk(3'b000, 3'b000, 3'b000, 12'h000, 24'h0, 3'b000, 4'h0, 8'h00, 0, 0, 0, 2'd0, 8'h12);
        vecs[22] = mk(3'b001, 3'b000, 3'b000, 12'h004, 24'h0, 3'b001, 4'h4, 8'h00, 0, 1, 1, 2'd0, 8'h3C);
        // Forwarding must not fire for a different address
        vecs[23] = mk(3'b010, 3'b010, 3'b000, 12'h020, 24'h007700, 3'b010, 4'h2, 8'h77, 1, 0, 0, 2'd0, 8'h3C);
        vecs[24] = mk(3'b001, 3'b000, 3'b000, 12'h003, 24'h0, 3'b001, 4'h3, 8'h00, 0, 1, 1, 2'd0, 8'h13);
        vecs[25] = mk(3'b001, 3'b000, 3'b000, 12'h002, 24'h0, 3'b001, 4'h2, 8'h00, 0, 1, 1, 2'd0, 8'h77);

        reset = 1'b1;
        req = 3'b111; we = 3'b000; lock = 3'b000; addr = 12'h321; wdata = '0;
        @(posedge clk);
        #1;
        chk("reset_gnt", -1, 32'(gnt), 32'h0);
        chk("reset_rf_rd", -1, 32'(rf_rd), 32'h0);
        chk("reset_rvalid", -1, 32'(rvalid), 32'h0);
        chk("reset_rid", -1, 32'(rid), 32'h0);
        chk("reset_rdata", -1, 32'(rdata), 32'h0);
        $display("reset gnt=%b rvalid=%0b rid=%0d rdata=%02h", gnt, rvalid, rid, rdata);
        reset = 1'b0;

        for (int n = 0; n < NV; n++) run_vec(n);

        // Reset in the middle of a locked read sequence
        req = 3'b100; we = 3'b000; lock = 3'b100; addr = 12'h300; wdata = '0;
        #4;
        chk("lockrst_gnt0", 100, 32'(gnt), 32'h4);
        @(posedge clk);
        #1;
        chk("lockrst_rvalid0", 100, 32'(rvalid), 32'h1);
        $display("lockrst first gnt=%b rvalid=%0b rid=%0d rdata=%02h", gnt, rvalid, rid, rdata);
        #2;
        chk("lockrst_gnt1", 101, 32'(gnt), 32'h4);
        reset = 1'b1;
        #1;
        chk("lockrst_rvalid_async", 101, 32'(rvalid), 32'h0);
        chk("lockrst_gnt_in_reset", 101, 32'(gnt), 32'h0);
        chk("lockrst_rf_rd_in_reset", 101, 32'(rf_rd), 32'h0);
        chk("lockrst_rdata", 101, 32'(rdata), 32'h0);
        $display("lockrst in reset gnt=%b rvalid=%0b rdata=%02h", gnt, rvalid, rdata);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req = 3'b110; lock = 3'b000; addr = 12'h321;
        #4;
        chk("lockrst_gnt_after", 102, 32'(gnt), 32'h2);
        chk("lockrst_rf_address", 102, 32'(rf_address), 32'h2);
        @(posedge clk);
        #1;
        chk("lockrst_rvalid_after", 102, 32'(rvalid), 32'h1);
        chk("lockrst_rid_after", 102, 32'(rid), 32'h1);
        chk("lockrst_rdata_after", 102, 32'(rdata), 32'h12);
        $display("lockrst after gnt=%b rvalid=%0b rid=%0d rdata=%02h", gnt, rvalid, rid, rdata);
        req = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
